signed_stall_buffer: RTL and testbench

- Multi-channel signed delay line with a stall-capable shift.
  - Stages 1..depth advance only when in_valid is high.
- Adds synchronous flush, a fill counter, and a full flag.
- Adds a runtime-selectable tap output with a qualifying valid.
- Sits between the ADC/FFE channel outputs and downstream consumers: FFE, MLSD and error checkers. These consumers need a history window that survives pipeline stalls.

---
 rtl/signed_buffer_pkg.sv | 13 +
 rtl/signed_stall_lane.sv | 48 ++++
 rtl/signed_stall_buffer.sv | 66 ++++++
 tb/tb_signed_stall_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/signed_buffer_pkg.sv
// Shared helpers for the signed stall buffer:
// tap select width and tap clamping.
package signed_buffer_pkg;

  function automatic int tap_width(input int d);
    return (d > 0) ? $clog2(d + 1) : 1;
  endfunction

  function automatic int clamp_tap(input int sel, input int d);
    return (sel > d) ? d : sel;
  endfunction

endpackage

// File: rtl/signed_stall_lane.sv
// One channel of the delay line: column 0 is the live
// sample, columns 1..depth advance only on in_valid.
module signed_stall_lane #(
  parameter int bitwidth = 8,
  parameter int depth    = 5
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic signed [bitwidth-1:0] in,
  input  logic                       in_valid,
  input  logic                       flush,
  output logic signed [bitwidth-1:0] hist [depth:0]
);

  assign hist[0] = in;

  if (depth > 0) begin : g_stages
    logic signed [bitwidth-1:0] stage_q [1:depth];
    logic signed [bitwidth-1:0] stage_d [1:depth];

    // Flush beats shift: the current sample never enters history.
    always_comb begin
      stage_d = stage_q;
      if (flush) begin
        for (int k = 1; k <= depth; k++) stage_d[k] = '0;
      end else if (in_valid) begin
        stage_d[1] = in;
        for (int k = 2; k <= depth; k++) stage_d[k] = stage_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        for (int k = 1; k <= depth; k++) stage_q[k] <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    for (genvar k = 1; k <= depth; k++) begin : g_out
      assign hist[k] = stage_q[k];
    end
  end else begin : g_none
    logic unused_ok;
    assign unused_ok = ^{clk, rstb, in_valid, flush};
  end

endmodule

// File: rtl/signed_stall_buffer.sv
// Multi-lane signed history window with stall, flush,
// shared fill counter and a clamped tap mux.
module signed_stall_buffer
  import signed_buffer_pkg::*;
#(
  parameter int numChannels = 16,
  parameter int bitwidth    = 8,
  parameter int depth       = 5
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic signed [bitwidth-1:0]    in [numChannels-1:0],
  input  logic                          in_valid,
  input  logic                          flush,
  input  logic [tap_width(depth)-1:0]   tap_sel,
  output logic signed [bitwidth-1:0]    buffer [numChannels-1:0][depth:0],
  output logic signed [bitwidth-1:0]    tap_out [numChannels-1:0],
  output logic                          tap_valid,
  output logic [tap_width(depth)-1:0]   fill_count,
  output logic                          full
);

  localparam int TW = tap_width(depth);
  localparam logic [TW-1:0] DMAX = TW'(depth);

  logic [TW-1:0] sel_c;

  for (genvar ch = 0; ch < numChannels; ch++) begin : g_lane
    signed_stall_lane #(
      .bitwidth(bitwidth),
      .depth   (depth)
    ) u_lane (
      .clk     (clk),
      .rstb    (rstb),
      .in      (in[ch]),
      .in_valid(in_valid),
      .flush   (flush),
      .hist    (buffer[ch])
    );
    assign tap_out[ch] = buffer[ch][sel_c];
  end

  if (depth > 0) begin : g_fill
    logic [TW-1:0] fill_q, fill_d;

    always_comb begin
      fill_d = fill_q;
      if (flush) fill_d = '0;
      else if (in_valid && fill_q != DMAX) fill_d = fill_q + TW'(1);
    end

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) fill_q <= '0;
      else       fill_q <= fill_d;
    end

    assign fill_count = fill_q;
  end else begin : g_nofill
    assign fill_count = '0;
  end

  assign sel_c     = TW'(clamp_tap(int'(tap_sel), depth));
  assign tap_valid = (sel_c <= fill_count);
  assign full      = (fill_count == DMAX);

endmodule

// File: tb/tb_signed_stall_buffer.sv
// Directed bench: depth=5 four-lane buffer plus a
// depth=0 build sharing clock and reset.
module tb_signed_stall_buffer;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  logic signed [7:0] din  [3:0];
  logic              in_valid, flush;
  logic [2:0]        tap_sel;
  logic signed [7:0] buf5 [3:0][5:0];
  logic signed [7:0] tout [3:0];
  logic              tap_valid, full;
  logic [2:0]        fill;

  logic signed [7:0] din0  [3:0];
  logic              v0, f0;
  logic [0:0]        sel0;
  logic signed [7:0] buf0  [3:0][0:0];
  logic signed [7:0] tout0 [3:0];
  logic              tv0, full0;
  logic [0:0]        fill0;

  int n_checks = 0;
  int n_err    = 0;

  signed_stall_buffer #(
    .numChannels(4), .bitwidth(8), .depth(5)
  ) dut (
    .clk(clk), .rstb(rstb), .in(din),
    .in_valid(in_valid), .flush(flush),
    .tap_sel(tap_sel), .buffer(buf5),
    .tap_out(tout), .tap_valid(tap_valid),
    .fill_count(fill), .full(full)
  );

  signed_stall_buffer #(
    .numChannels(4), .bitwidth(8), .depth(0)
  ) dut0 (
    .clk(clk), .rstb(rstb), .in(din0),
    .in_valid(v0), .flush(f0),
    .tap_sel(sel0), .buffer(buf0),
    .tap_out(tout0), .tap_valid(tv0),
    .fill_count(fill0), .full(full0)
  );

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int base);
    for (int ch = 0; ch < 4; ch++) din[ch] = 8'(base + ch);
  endtask

  int tap_exp [8] = '{2, 51, 41, 31, 21, 11, 11, 11};

  initial begin
    rstb = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    tap_sel = 3'd0;
    set_in(0);
    for (int ch = 0; ch < 4; ch++) din0[ch] = -8'sd5;
    v0 = 1'b0;
    f0 = 1'b0;
    sel0 = 1'b0;

    // reset state
    tick();
    check("rst_fill", fill, 0);
    check("rst_full", full, 0);
    check("rst_stage", buf5[2][3], 0);
    check("rst_tv0", tap_valid, 1);
    tap_sel = 3'd3;
    #1;
    check("rst_tv3", tap_valid, 0);
    check("rst_tap3", tout[1], 0);
    tap_sel = 3'd0;
    @(negedge clk);
    rstb = 1'b1;

    // fill
    for (int n = 0; n < 6; n++) begin
      set_in(10 * n);
      in_valid = 1'b1;
      tick();
      check("fill_cnt", fill, (n < 5) ? n + 1 : 5);
      if (n == 4) begin
        check("fill_b25", buf5[2][5], 2);
        check("fill_b21", buf5[2][1], 42);
        check("fill_full", full, 1);
      end
    end
    check("sat_b21", buf5[2][1], 52);
    check("sat_b25", buf5[2][5], 12);

    // stall
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(90 + 10 * i);
      #1;
      check("stall_live", buf5[2][0], 92 + 10 * i);
      tick();
      check("stall_b31", buf5[3][1], 53);
      check("stall_b05", buf5[0][5], 10);
      check("stall_cnt", fill, 5);
    end

    // tap sweep on full buffer
    set_in(1);
    for (int s = 0; s < 8; s++) begin
      tap_sel = 3'(s);
      #1;
      check("tap_out", tout[1], tap_exp[s]);
      check("tap_valid", tap_valid, 1);
    end

    // flush wins over shift
    flush = 1'b1;
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_b01", buf5[0][1], 0);
    check("fl_b35", buf5[3][5], 0);
    check("fl_cnt", fill, 0);
    check("fl_full", full, 0);

    set_in(20);
    tick();
    set_in(30);
    tick();
    in_valid = 1'b0;
    check("re_cnt", fill, 2);
    for (int s = 0; s < 8; s++) begin
      tap_sel = 3'(s);
      #1;
      check("re_tv", tap_valid, (s <= 2) ? 1 : 0);
      if (s == 2) check("re_tap2", tout[0], 20);
    end
    tap_sel = 3'd0;

    // extremes then async reset
    in_valid = 1'b1;
    for (int ch = 0; ch < 4; ch++)
      din[ch] = ch[0] ? 8'sd127 : -8'sd128;
    tick();
    for (int ch = 0; ch < 4; ch++)
      din[ch] = ch[0] ? -8'sd128 : 8'sd127;
    tick();
    in_valid = 1'b0;
    check("ext_b01", buf5[0][1], 127);
    check("ext_b02", buf5[0][2], -128);
    check("ext_b11", buf5[1][1], -128);
    check("ext_cnt", fill, 4);
    #2;
    rstb = 1'b0;
    #1;
    check("ar_b01", buf5[0][1], 0);
    check("ar_b12", buf5[1][2], 0);
    check("ar_cnt", fill, 0);
    check("ar_full", full, 0);
    @(negedge clk);
    rstb = 1'b1;
    for (int ch = 0; ch < 4; ch++) din[ch] = -8'sd128;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_b11", buf5[1][1], -128);
    check("post_b21", buf5[2][1], -128);
    check("post_cnt", fill, 1);

    // depth=0 build ignores flush/in_valid
    for (int i = 0; i < 4; i++) begin
      v0 = i[0];
      f0 = i[1];
      sel0 = i[0];
      tick();
      check("d0_buf", buf0[2][0], -5);
      check("d0_tap", tout0[1], -5);
      check("d0_full", full0, 1);
      check("d0_fill", fill0, 0);
      check("d0_tv", tv0, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
